// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM encoding, default baud divisor
// and a parity helper for the transmitter and a future receiver.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 1085;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Even mode gives the plain XOR; odd mode inverts it.
  function automatic logic parity_bit(input logic [8:0] data, input int unsigned mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Byte handshake between a byte source and the UART transmitter.
interface uart_tx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter with synchronous restart; strobes in the last cycle of
// every bit period and wraps to zero.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_end_c
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  assign bit_end_c = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || bit_end_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a one-entry holding register so that
// queued bytes leave back-to-back with no idle gap.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PAR_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_param_if.slave bus,
  output logic           txd,
  output logic           busy,
  output logic           frame_done
);

  localparam int unsigned IW = $clog2(DATA_BITS + 1);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_tx_param: CLKS_PER_BIT must be 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY > PAR_EVEN) begin : g_bad_par
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  state_t               state;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] shifter;
  logic                 hold_empty;
  logic                 par_bit;
  logic [IW-1:0]        bit_idx;
  logic                 bit_end_c;
  logic                 accept_c;
  logic                 last_data_c;
  logic                 last_stop_c;
  logic                 frame_end_c;
  logic                 load_c;
  logic                 restart_c;

  assign bus.tx_ready = hold_empty;
  assign accept_c     = bus.tx_valid && hold_empty;
  assign last_data_c  = (bit_idx == IW'(DATA_BITS - 1));
  assign last_stop_c  = (bit_idx == IW'(STOP_BITS - 1));
  assign frame_end_c  = (state == ST_STOP) && bit_end_c && last_stop_c;
  assign load_c       = !hold_empty && ((state == ST_IDLE) || frame_end_c);
  // Counter parks at zero while idle so every frame starts on a fresh period.
  assign restart_c    = (state == ST_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (restart_c),
    .bit_end_c(bit_end_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      hold       <= '0;
      shifter    <= '0;
      hold_empty <= 1'b1;
      par_bit    <= 1'b0;
      bit_idx    <= '0;
      txd        <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // Accept needs an empty holding register and load needs a full one,
      // so the two never collide.
      if (accept_c) begin
        hold       <= bus.tx_data;
        hold_empty <= 1'b0;
      end else if (load_c) begin
        hold_empty <= 1'b1;
      end

      if (load_c) begin
        shifter <= hold;
        par_bit <= parity_bit(9'(hold), PARITY);
      end

      case (state)
        ST_IDLE: begin
          if (load_c) state <= ST_START;
        end
        ST_START: begin
          if (bit_end_c) begin
            state   <= ST_DATA;
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (bit_end_c) begin
            shifter <= shifter >> 1;
            if (last_data_c) begin
              bit_idx <= '0;
              state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (bit_end_c) begin
            state   <= ST_STOP;
            bit_idx <= '0;
          end
        end
        ST_STOP: begin
          if (bit_end_c) begin
            if (last_stop_c) begin
              bit_idx <= '0;
              state   <= hold_empty ? ST_IDLE : ST_START;
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Line outputs follow the current state, so txd, busy and frame_done
      // stay aligned with each other one cycle behind the FSM.
      busy       <= (state != ST_IDLE);
      frame_done <= frame_end_c;
      case (state)
        ST_START:  txd <= 1'b0;
        ST_DATA:   txd <= shifter[0];
        ST_PARITY: txd <= par_bit;
        default:   txd <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations (8N1, 8E1, 8O1, 7N2) at four
// clocks per bit, checked against a frame-level reference model.
module tb_uart_tx_param;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] data [4];
  logic [3:0] valid;
  logic [3:0] ready_v, txd_v, busy_v, fd_v;
  int         cyc = 0;
  int         passed = 0, total = 0;

  logic [8:0] exp_mem [4][64];
  int         wr [4], rd [4], frames [4], idle_bad [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_param_if #(.DATA_BITS(8)) bus0 ();
  uart_tx_param_if #(.DATA_BITS(8)) bus1 ();
  uart_tx_param_if #(.DATA_BITS(8)) bus2 ();
  uart_tx_param_if #(.DATA_BITS(7)) bus3 ();

  assign bus0.tx_data = data[0][7:0];  assign bus0.tx_valid = valid[0];  assign ready_v[0] = bus0.tx_ready;
  assign bus1.tx_data = data[1][7:0];  assign bus1.tx_valid = valid[1];  assign ready_v[1] = bus1.tx_ready;
  assign bus2.tx_data = data[2][7:0];  assign bus2.tx_valid = valid[2];  assign ready_v[2] = bus2.tx_ready;
  assign bus3.tx_data = data[3][6:0];  assign bus3.tx_valid = valid[3];  assign ready_v[3] = bus3.tx_ready;

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .txd(txd_v[0]), .busy(busy_v[0]), .frame_done(fd_v[0]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .txd(txd_v[1]), .busy(busy_v[1]), .frame_done(fd_v[1]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .txd(txd_v[2]), .busy(busy_v[2]), .frame_done(fd_v[2]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .txd(txd_v[3]), .busy(busy_v[3]), .frame_done(fd_v[3]));

  function automatic int db_of(input int k);  return (k == 3) ? 7 : 8;  endfunction
  function automatic int par_of(input int k); return (k == 1) ? 2 : ((k == 2) ? 1 : 0); endfunction
  function automatic int sb_of(input int k);  return (k == 3) ? 2 : 1;  endfunction
  function automatic logic [8:0] dmask(input int k); return 9'((1 << db_of(k)) - 1); endfunction

  // Reference frame: start, data LSB first, optional parity, stop bits.
  function automatic int model_frame(input int k, input logic [8:0] d, output logic [15:0] eb);
    int p;
    logic [8:0] dm;
    eb = '0;
    dm = d & dmask(k);
    p  = 1;
    for (int i = 0; i < db_of(k); i++) begin eb[p] = dm[i]; p++; end
    if (par_of(k) != 0) begin
      eb[p] = (^dm) ^ (par_of(k) == 1);
      p++;
    end
    for (int s = 0; s < sb_of(k); s++) begin eb[p] = 1'b1; p++; end
    return p;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void push(input int k, input logic [8:0] b);
    exp_mem[k][wr[k] % 64] = b & dmask(k);
    wr[k]++;
  endfunction

  // Independent line monitor: every frame must match the next queued byte.
  task automatic monitor(input int k);
    logic [15:0] eb;
    logic [8:0]  d;
    int          n, bad_t, bad_b, bad_f;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (txd_v[k]) begin
        if (busy_v[k] || fd_v[k]) idle_bad[k]++;
        continue;
      end
      if (rd[k] == wr[k]) begin
        check($sformatf("mon%0d unexpected frame", k), 1, 0);
        d = '0;
      end else begin
        d = exp_mem[k][rd[k] % 64];
        rd[k]++;
      end
      n = model_frame(k, d, eb) * CPB;
      bad_t = 0; bad_b = 0; bad_f = 0; aborted = 0;
      for (int c = 0; c < n; c++) begin
        if (c > 0) @(negedge clk);
        if (!rst_n) begin aborted = 1; break; end
        if (txd_v[k] !== eb[c / CPB]) bad_t++;
        if (busy_v[k] !== 1'b1) bad_b++;
        if (fd_v[k] !== (c == n - 1)) bad_f++;
      end
      if (!aborted) begin
        check($sformatf("mon%0d txd cycles data=%0h", k, d), bad_t, 0);
        check($sformatf("mon%0d busy cycles", k), bad_b, 0);
        check($sformatf("mon%0d frame_done cycles", k), bad_f, 0);
        frames[k]++;
      end
    end
  endtask

  task automatic send(input int k, input logic [8:0] b, input bit keep, output int acc);
    @(negedge clk);
    data[k]  = b;
    valid[k] = 1'b1;
    for (int t = 0; t < 200 && !ready_v[k]; t++) @(negedge clk);
    if (!ready_v[k]) begin
      check($sformatf("send%0d ready timeout", k), 0, 1);
      valid[k] = 1'b0;
      acc = -1;
      return;
    end
    push(k, b);
    @(posedge clk);
    #1;
    acc = cyc;
    if (!keep) valid[k] = 1'b0;
  endtask

  task automatic capture(input int k, output logic [15:0] bits, output int ncyc,
                         output int nfd, output int nbusy, output int start_cyc);
    bits = '0; ncyc = 0; nfd = 0; nbusy = 0; start_cyc = -1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!txd_v[k]) begin start_cyc = cyc; break; end
    end
    if (start_cyc < 0) begin
      check($sformatf("cap%0d start timeout", k), 0, 1);
      return;
    end
    for (int c = 0; c < 64; c++) begin
      if (c > 0) @(negedge clk);
      if (c % CPB == CPB / 2) bits[c / CPB] = txd_v[k];
      nfd   += int'(fd_v[k]);
      nbusy += int'(busy_v[k]);
      if (fd_v[k]) begin ncyc = c + 1; break; end
    end
  endtask

  typedef struct {
    int          k;
    logic [8:0]  d;
    logic [15:0] frame;
    int          nbits;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [9];
    logic [15:0] bits;
    int          ncyc, nfd, nbusy, st, acc1, acc2, bad, lows;
    bit          got;

    vecs[0] = '{0, 9'h05A, 16'({1'b1, 8'h5A, 1'b0}), 10};
    vecs[1] = '{1, 9'h05A, 16'({1'b1, 1'b0, 8'h5A, 1'b0}), 11};
    vecs[2] = '{2, 9'h05A, 16'({1'b1, 1'b1, 8'h5A, 1'b0}), 11};
    vecs[3] = '{1, 9'h001, 16'({1'b1, 1'b1, 8'h01, 1'b0}), 11};
    vecs[4] = '{2, 9'h001, 16'({1'b1, 1'b0, 8'h01, 1'b0}), 11};
    vecs[5] = '{3, 9'h07F, 16'({2'b11, 7'h7F, 1'b0}), 10};
    vecs[6] = '{3, 9'h180, 16'({2'b11, 7'h00, 1'b0}), 10};
    vecs[7] = '{0, 9'h000, 16'({1'b1, 8'h00, 1'b0}), 10};
    vecs[8] = '{0, 9'h0FF, 16'({1'b1, 8'hFF, 1'b0}), 10};

    for (int k = 0; k < 4; k++) begin
      data[k] = '0; wr[k] = 0; rd[k] = 0; frames[k] = 0; idle_bad[k] = 0;
    end
    valid = '0;
    rst_n = 1'b0;
    fork
      monitor(0); monitor(1); monitor(2); monitor(3);
    join_none

    repeat (3) @(negedge clk);
    check("reset txd", int'(txd_v), 15);
    check("reset ready", int'(ready_v), 15);
    check("reset busy", int'(busy_v), 0);
    check("reset frame_done", int'(fd_v), 0);
    rst_n = 1'b1;

    // Single frames from idle across all configurations.
    foreach (vecs[i]) begin
      send(vecs[i].k, vecs[i].d, 1'b0, acc1);
      capture(vecs[i].k, bits, ncyc, nfd, nbusy, st);
      check($sformatf("vec%0d frame bits", i), int'(bits & 16'((1 << vecs[i].nbits) - 1)),
            int'(vecs[i].frame));
      check($sformatf("vec%0d frame cycles", i), ncyc, vecs[i].nbits * CPB);
      check($sformatf("vec%0d frame_done pulses", i), nfd, 1);
      check($sformatf("vec%0d busy cycles", i), nbusy, vecs[i].nbits * CPB);
      check($sformatf("vec%0d start latency", i), st - acc1, 2);
    end

    // Back-to-back: valid held high across two bytes.
    send(0, 9'h041, 1'b1, acc1);
    data[0] = 9'h042;
    got = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ready_v[0]) begin got = 1; break; end
    end
    check("b2b second accept", int'(got), 1);
    acc2 = acc1 + 1000;
    if (got) begin
      push(0, 9'h042);
      @(posedge clk);
      #1;
      acc2 = cyc;
    end
    valid[0] = 1'b0;
    check("b2b accepted during first frame", int'(acc2 - acc1 < 2 + 10 * CPB), 1);
    got = 0; bad = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (fd_v[0]) begin got = 1; break; end
      if (ready_v[0]) bad++;
    end
    check("b2b first frame_done", int'(got), 1);
    check("b2b ready low while queued", bad, 0);
    @(negedge clk);
    check("b2b zero gap start", int'(txd_v[0]), 0);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (fd_v[0]) break;
    end

    // Async reset during data bit 3 with a second byte still queued.
    send(0, 9'h0A5, 1'b0, acc1);
    send(0, 9'h05C, 1'b0, acc2);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (!txd_v[0]) break;
    end
    repeat (17) @(negedge clk);
    check("rst pre txd (data bit 3)", int'(txd_v[0]), 0);
    check("rst pre ready", int'(ready_v[0]), 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst async txd", int'(txd_v), 15);
    check("rst async ready", int'(ready_v), 15);
    check("rst async busy", int'(busy_v), 0);
    for (int k = 0; k < 4; k++) rd[k] = wr[k];
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (!txd_v[0]) lows++;
    end
    check("rst no residual frame", lows, 0);
    send(0, 9'h033, 1'b0, acc1);
    capture(0, bits, ncyc, nfd, nbusy, st);
    check("rst new frame bits", int'(bits & 16'h03FF), int'(16'({1'b1, 8'h33, 1'b0})));
    check("rst new frame cycles", ncyc, 10 * CPB);

    // Random traffic, data toggling freely while not ready.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        data[k]  = 9'($urandom);
        valid[k] = ($urandom_range(0, (n < 1500) ? 7 : 1) == 0);
        if (valid[k] && ready_v[k]) push(k, data[k]);
      end
    end
    @(negedge clk);
    valid = '0;
    repeat (150) @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      check($sformatf("dut%0d queue drained", k), wr[k] - rd[k], 0);
      check($sformatf("dut%0d idle busy/frame_done glitches", k), idle_bad[k], 0);
      check($sformatf("dut%0d frames seen", k), int'(frames[k] > 20), 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter. Successor to the fixed 8N1 switch-driven transmitter.
- Accepts bytes over a valid/ready handshake.
- Supports configurable data width, parity and stop bits.
- Has a one-entry holding register, so frames go out back-to-back with no idle gap.
- Sits between the system's byte source (command/ASCII encoder logic) and the board TX pin.

Parameters:
- CLKS_PER_BIT, 1085, clock cycles per bit period (1085 = 115200 baud at 125 MHz); legal range 2..65535.
- DATA_BITS, 8, data bits per frame, LSB first; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame: 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tx_data  input  DATA_BITS  byte to send; sampled on handshake.
- tx_valid  input  1  source has data on tx_data.
- tx_ready  output  1  holding register empty; transfer occurs when tx_valid && tx_ready at a rising edge.
- txd  output  1  serial line, idle high; registered output.
- busy  output  1  high while a frame is on the line (START through last STOP).
- frame_done  output  1  one-cycle pulse in the last cycle of the final stop bit.

Behaviour:
- Reset (asynchronous, rst_n=0): txd=1, tx_ready=1, busy=0, frame_done=0, holding register empty, FSM=IDLE, baud counter=0. Asserting reset mid-frame aborts the frame immediately; txd returns high at once.
- Holding register:
  - Loaded on handshake; tx_ready deasserts the following cycle.
  - Frees (tx_ready=1) in the cycle the shifter loads from it.
  - Holding register plus shifter allow one byte queued while another is sent.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - txd=1.
  - If the holding register is full: load the shifter, clear the holding register, and enter START on the next edge.
  - Latency from accepting handshake (idle line) to txd falling = 2 clk cycles.
- Baud counter:
  - Restarts at 0 on entry to START; it is not free-running, so frame timing is independent of request phase.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - The bit-end strobe fires when the counter equals CLKS_PER_BIT-1; the counter then wraps to 0.
- START: txd=0 for one bit → DATA.
- DATA:
  - txd = shifter[0]; shift right on each bit-end.
  - Bit index 0..DATA_BITS-1.
  - After the last data bit → PARITY if PARITY≠0, else STOP.
- PARITY:
  - txd = XOR of data bits (even mode) or its inverse (odd mode).
  - Computed from the latched data, never from live tx_data.
- STOP:
  - txd=1 for STOP_BITS bit periods.
  - In the final cycle: frame_done=1.
  - If the holding register is full, go directly to START with no extra idle cycle. Back-to-back frames have zero gap.
  - Otherwise go to IDLE.
- Simultaneous events:
  - A handshake in the same cycle the shifter loads from the holding register is legal (holding frees and refills together); no byte is lost or duplicated.
  - A handshake on the final STOP cycle while holding is empty is accepted, but the byte goes out after one IDLE cycle. This 1-cycle gap is allowed.
- tx_data/tx_valid changes while tx_ready=0 are ignored.
- busy = (FSM ≠ IDLE).
- Width rules:
  - Baud counter width = clog2(CLKS_PER_BIT).
  - Bit index width = clog2(DATA_BITS+1).
  - Counters never overflow.
- Illegal parameter values trigger an elaboration-time error (generate-time check).

Decomposition:
- Shared package uart_pkg holds:
  - parity mode constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - FSM state encoding constants;
  - a default baud constant 1085.
- One sub-module, uart_baud_gen: counter with sync restart input and a bit-end strobe output, parametrised by CLKS_PER_BIT. It is reusable by a future uart_rx_param.

Test Plan:
- Test 1, basic 8N1 frame. CLKS_PER_BIT=4, 8N1; send 0x5A from idle.
  - txd falls 2 cycles after handshake.
  - Bit sequence 0 | 0,1,0,1,1,0,1,0 | 1, each bit exactly 4 cycles.
  - frame_done pulses once at cycle 40 of the frame; busy high for 40 cycles.
- Test 2, parity modes. PARITY=2 then PARITY=1 with 0x5A: parity bit is 0 (even) and 1 (odd). With 0x01: parity bit is 1 (even) and 0 (odd). Frame length is 11 bits.
- Test 3, back-to-back frames. Hold tx_valid high with 0x41 then 0x42.
  - Second handshake is accepted during the first frame.
  - Second start bit begins the cycle after the first frame_done, with zero idle cycles.
  - tx_ready low between the second accept and the second START.
- Test 4, variant widths. DATA_BITS=7, STOP_BITS=2, send 0x7F: txd low for 1 bit, high for 7+2 bits; total 10 bit periods; frame_done in the last cycle only.
- Test 5, reset mid-frame. Assert rst_n=0 during DATA bit 3 (asynchronously, between edges).
  - txd=1 and tx_ready=1 immediately; busy=0.
  - After release, no residual frame is emitted; a new byte 0x33 sends cleanly.
- Test 6, handshake ignored while not ready. Toggle tx_data randomly while tx_ready=0: the transmitted byte equals the value present at the accepting edge.
